// File: rtl/stream_mux_pkg.sv
// Shared definitions for the N-channel stream multiplexer: mode encoding,
// channel limits and the rotating-priority pick used by the arbiter.
package stream_mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  localparam int unsigned max_ch = 16;
  localparam int unsigned PTR_W  = $clog2(max_ch);

  typedef logic [max_ch-1:0] ch_vec_t;
  typedef logic [PTR_W-1:0]  ch_idx_t;

  // One-hot grant of the first set bit of valid[n-1:0], searching upward from
  // ptr and wrapping modulo n.
  function automatic ch_vec_t rr_pick(input ch_vec_t     valid,
                                      input ch_idx_t     ptr,
                                      input int unsigned n);
    ch_vec_t gnt;
    ch_idx_t idx;
    logic    found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 0; off < max_ch; off++) begin
      idx = PTR_W'((32'(ptr) + off) % n);
      if (off < n && !found && valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its binary index.
// The rotating pointer is owned by the instantiating block.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH  = 3,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N_CH-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx
);

  always_comb begin
    gnt = '0;
    if (en) begin
      gnt = N_CH'(rr_pick(max_ch'(req), PTR_W'(ptr), N_CH));
    end
  end

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        gnt_idx = i[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// N-channel registered stream multiplexer with fixed-select or round-robin
// channel choice and a single full-throughput output register.
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter  int unsigned DATA_W = 136,
  parameter  int unsigned N_CH   = 3,
  localparam int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  logic              rr_mode;
  logic              can_load;
  logic              load;
  logic [SEL_W-1:0]  rr_ptr;
  logic [N_CH-1:0]   fix_gnt;
  logic [N_CH-1:0]   rr_gnt;
  logic [SEL_W-1:0]  rr_idx;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [DATA_W-1:0] grant_data;

  assign rr_mode  = (mode == MODE_RR);
  assign can_load = !out_valid || out_ready;

  // Fixed-mode decode; an out-of-range sel grants nothing.
  always_comb begin
    fix_gnt = '0;
    if (!rr_mode && 32'(sel) < N_CH) begin
      fix_gnt[sel] = in_valid[sel];
    end
  end

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_rr_arbiter (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .en      (rr_mode),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  assign grant     = rr_mode ? rr_gnt : fix_gnt;
  assign grant_idx = rr_mode ? rr_idx : sel;

  // rst_n gate keeps every in_ready low while reset is held, even though
  // can_load is high with the register empty.
  assign in_ready = grant & {N_CH{can_load & rst_n}};
  assign load     = |in_ready;

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      grant_data = grant_data | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
        if (rr_mode) begin
          if (32'(grant_idx) == N_CH - 1) begin
            rr_ptr <= '0;
          end else begin
            rr_ptr <= grant_idx + 1'b1;
          end
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-channel registered stream multiplexer with valid/ready handshakes on every input and on the output. It selects one input channel per transfer, either by a fixed `sel` input or by round-robin arbitration, and holds the accepted word in a single output register with full-throughput back-pressure. It is the next-generation replacement for the fixed three-input 136-bit `mux` in the datapath, and feeds the downstream stage that consumes 136-bit words.

## Interface
- `DATA_W`, 136, width of one data word
- `N_CH`, 3, number of input channels (2..16)
- `SEL_W`, `$clog2(N_CH)`, width of `sel` and `out_ch` (derived, not overridden)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mode`  in  1  0 = fixed select, 1 = round-robin
- `sel`  in  SEL_W  channel index used in fixed mode
- `in_valid`  in  N_CH  per-channel valid
- `in_data`  in  N_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- `in_ready`  out  N_CH  per-channel ready
- `out_valid`  out  1  output register holds a word
- `out_data`  out  DATA_W  registered word
- `out_ch`  out  SEL_W  index of the channel that supplied `out_data`
- `out_ready`  in  1  downstream accepts the word

## Operation
- Reset values: `out_valid`=0, `out_data`=0, `out_ch`=0, round-robin pointer `rr_ptr`=0. `in_ready` is all-zero while `rst_n`=0.
- `can_load` = `!out_valid || out_ready`.
- Grant is a combinational one-hot function of `mode`, `sel`, `in_valid` and `rr_ptr`. It never depends on `out_ready`.
  - Fixed mode: grant channel `sel` if `in_valid[sel]`. If `sel >= N_CH`, nothing is granted and all `in_ready` = 0.
  - Round-robin mode: grant the first channel with `in_valid` set, searching `rr_ptr`, `rr_ptr+1`, ... modulo N_CH.
- `in_ready[i]` = `grant[i] && can_load`. At most one bit is set per cycle.
- Input transfer on channel i occurs when `in_valid[i] && in_ready[i]`. On that edge:
  - `out_data` ← channel i data
  - `out_ch` ← i
  - `out_valid` ← 1
- Output transfer occurs when `out_valid && out_ready`. With no simultaneous input transfer, `out_valid` ← 0. `out_data` and `out_ch` hold their last values.
- Simultaneous output and input transfer: the register is replaced in the same edge, `out_valid` stays 1, and there is no bubble.
- `rr_ptr` ← (i+1) mod N_CH after every input transfer in round-robin mode only. Fixed-mode transfers leave `rr_ptr` unchanged.
- While `out_valid && !out_ready`, `out_data` and `out_ch` are stable and no input is accepted.
- A `mode` or `sel` change affects only the next grant. It never alters or drops the word already in the output register.
- Asserting reset mid-stream discards the held word immediately. In-flight input words are not accepted.

## Timing
- Latency is 1 cycle: a word accepted at edge k is visible on `out_data` after edge k.
- Throughput is 1 word/cycle when `out_ready` stays high.
- Combinational paths: `in_valid`/`mode`/`sel` → `in_ready`, and `out_ready` → `in_ready`. There is no path from any input to `out_*`.
- Round-robin fairness: with all channels continuously valid and `out_ready`=1, every channel is served exactly once in every N_CH consecutive transfers.
- Input protocol: producers keep `in_valid` and data stable until accepted. The block does not check this.

## Structure
- Package `stream_mux_pkg`:
  - `MODE_FIXED` = 1'b0, `MODE_RR` = 1'b1
  - `max_ch` constant = 16
  - helper function `rr_pick(valid, ptr)` returning a one-hot grant
- Sub-module `rr_arbiter`, parametrised by N_CH:
  - Inputs: `req`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and `gnt_idx`.
  - Purely combinational; `rr_ptr` stays in `stream_mux`.
- Top level contains the fixed-mode decode, the grant mux between fixed and round-robin, the output register and `rr_ptr`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `in_ready`=0. Release, then after one edge with `mode`=0 and `sel`=0 → `out_data`=channel 0 word, `out_ch`=0.
- Fixed select, DATA_W=136, N_CH=3, `sel`=1, `in_data[1]`=136'h0123456789abcdef0123456789abcdef, `out_ready`=1 → the word appears 1 cycle later with `out_ch`=1. Then set `sel`=3 → `in_ready`=0 and `out_valid` drops after the pending word drains.
- Round-robin, all 3 channels valid, `out_ready`=1 for 6 cycles → `out_ch` sequence 0,1,2,0,1,2 with no bubbles.
- Back-pressure: `out_ready`=0 for 4 cycles with a word held → `out_data`/`out_ch` stable and `in_ready`=0. Raising `out_ready` drains and reloads in the same edge, so `out_valid` stays 1.
- Sparse round-robin: only channels 0 and 2 valid, `rr_ptr`=1 → grant 2 first, then 0. Mode switch to fixed (`sel`=0) while a word is held → the held word is delivered unchanged and `rr_ptr` stays frozen.
- Reset mid-stream: assert `rst_n`=0 asynchronously mid-cycle while `out_valid`=1 → `out_valid`=0 immediately, without waiting for a clock edge.
